// File: rtl/adder_sequencer_32b_pkg.sv
// Shared types and constants for the multi-word adder sequencer.
package adder_seq_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } adder_seq_state_e;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_sequencer_32b_rr_arbiter.sv
// Round-robin arbiter: priority starts one past the last grant; the pointer
// moves only when the caller signals a completed handshake.
module rr_arbiter
  import adder_seq_pkg::*;
#(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = idx_width(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic          adv_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] sel;
  logic          found;
  int unsigned   idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(last_q) + i) % N;
      sel = IW'(idx);
      if (!found && req_i[sel]) begin
        found      = 1'b1;
        gnt_o[sel] = 1'b1;
        gnt_idx_o  = sel;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (adv_i) begin
      last_d = gnt_idx_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= IW'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/adder_sequencer_32b.sv
// Shares one external 32-bit adder among requesters, sequencing multi-word adds
// LSW first with carry chaining. Optional `ADDER_SEQ_OVERFLOW_EN adds rsp_ovf_o.
module adder_sequencer_32b
  import adder_seq_pkg::*;
#(
  parameter  int unsigned NUM_REQ   = 2,
  parameter  int unsigned MAX_WORDS = 4,
  localparam int unsigned IW        = idx_width(NUM_REQ),
  localparam int unsigned WW        = idx_width(MAX_WORDS)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_REQ-1:0]                    req_valid_i,
  output logic [NUM_REQ-1:0]                    req_ready_o,
  input  logic [NUM_REQ*WW-1:0]                 req_words_i,
  input  logic [NUM_REQ-1:0]                    req_carry_i,
  input  logic [NUM_REQ*MAX_WORDS*WORD_W-1:0]   req_op1_i,
  input  logic [NUM_REQ*MAX_WORDS*WORD_W-1:0]   req_op2_i,
  output logic [WORD_W-1:0]                     add_op1_o,
  output logic [WORD_W-1:0]                     add_op2_o,
  output logic                                  add_carry_o,
  input  logic [WORD_W-1:0]                     add_sum_i,
  input  logic                                  add_carry_i,
  output logic                                  rsp_valid_o,
  input  logic                                  rsp_ready_i,
  output logic [IW-1:0]                         rsp_id_o,
  output logic [MAX_WORDS*WORD_W-1:0]           rsp_sum_o,
  output logic                                  rsp_carry_o
`ifdef ADDER_SEQ_OVERFLOW_EN
  ,
  output logic                                  rsp_ovf_o
`endif
);

  localparam int unsigned BLK = MAX_WORDS * WORD_W;

  typedef logic [MAX_WORDS-1:0][WORD_W-1:0] opvec_t;

  opvec_t           op1_arr   [NUM_REQ];
  opvec_t           op2_arr   [NUM_REQ];
  logic [WW-1:0]    words_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op1_arr[g]   = req_op1_i[g*BLK +: BLK];
    assign op2_arr[g]   = req_op2_i[g*BLK +: BLK];
    assign words_arr[g] = req_words_i[g*WW +: WW];
  end

  adder_seq_state_e state_q, state_d;
  opvec_t           op1_q, op1_d;
  opvec_t           op2_q, op2_d;
  opvec_t           sum_q, sum_d;
  logic [WW-1:0]    cnt_q, cnt_d;
  logic [WW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    id_q, id_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               accept;
  logic               last_word;
  logic [WORD_W-1:0]  op1_w, op2_w;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_valid_i),
    .adv_i     (accept),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign accept      = (state_q == IDLE) && (|req_valid_i);
  assign req_ready_o = (state_q == IDLE) ? gnt : '0;
  assign last_word   = (k_q == cnt_q);
  assign op1_w       = op1_q[k_q];
  assign op2_w       = op2_q[k_q];

  assign add_op1_o   = (state_q == RUN) ? op1_w   : '0;
  assign add_op2_o   = (state_q == RUN) ? op2_w   : '0;
  assign add_carry_o = (state_q == RUN) ? carry_q : 1'b0;

  assign rsp_valid_o = (state_q == DONE);
  assign rsp_id_o    = id_q;
  assign rsp_sum_o   = sum_q;
  assign rsp_carry_o = carry_q;

  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    carry_d = carry_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op1_d   = op1_arr[gnt_idx];
          op2_d   = op2_arr[gnt_idx];
          cnt_d   = words_arr[gnt_idx];
          carry_d = req_carry_i[gnt_idx];
          id_d    = gnt_idx;
          sum_d   = '0;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[k_q] = add_sum_i;
        carry_d    = add_carry_i;
        k_d        = k_q + 1'b1;
        if (last_word) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op1_q   <= '0;
      op2_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      id_q    <= id_d;
    end
  end

`ifdef ADDER_SEQ_OVERFLOW_EN
  logic ovf_q, ovf_d;

  // Signed overflow is judged on the top word only, in its RUN cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (accept) begin
      ovf_d = 1'b0;
    end else if ((state_q == RUN) && last_word) begin
      ovf_d = (op1_w[WORD_W-1] == op2_w[WORD_W-1]) &&
              (add_sum_i[WORD_W-1] != op1_w[WORD_W-1]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign rsp_ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_adder_sequencer_32b.sv
// Directed self-checking bench for adder_sequencer_32b (2 requesters, 4 words).
module tb_adder_sequencer_32b;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [1:0]   req_valid_i;
  logic [1:0]   req_ready_o;
  logic [3:0]   req_words_i;
  logic [1:0]   req_carry_i;
  logic [255:0] req_op1_i;
  logic [255:0] req_op2_i;
  logic [31:0]  add_op1_o, add_op2_o, add_sum_i;
  logic         add_carry_o, add_carry_i;
  logic         rsp_valid_o, rsp_ready_i;
  logic [0:0]   rsp_id_o;
  logic [127:0] rsp_sum_o;
  logic         rsp_carry_o;
`ifdef ADDER_SEQ_OVERFLOW_EN
  logic         rsp_ovf_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Stand-in for the shared prefix adder.
  assign {add_carry_i, add_sum_i} = {1'b0, add_op1_o} + {1'b0, add_op2_o} + {32'd0, add_carry_o};

  adder_sequencer_32b #(
    .NUM_REQ   (2),
    .MAX_WORDS (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_words_i (req_words_i),
    .req_carry_i (req_carry_i),
    .req_op1_i   (req_op1_i),
    .req_op2_i   (req_op2_i),
    .add_op1_o   (add_op1_o),
    .add_op2_o   (add_op2_o),
    .add_carry_o (add_carry_o),
    .add_sum_i   (add_sum_i),
    .add_carry_i (add_carry_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_id_o    (rsp_id_o),
    .rsp_sum_o   (rsp_sum_o),
    .rsp_carry_o (rsp_carry_o)
`ifdef ADDER_SEQ_OVERFLOW_EN
    ,
    .rsp_ovf_o   (rsp_ovf_o)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic set_req(input bit r, input logic [127:0] a, input logic [127:0] b,
                         input logic [1:0] w, input logic c);
    if (r == 1'b0) begin
      req_op1_i[127:0] = a; req_op2_i[127:0] = b; req_words_i[1:0] = w; req_carry_i[0] = c;
    end else begin
      req_op1_i[255:128] = a; req_op2_i[255:128] = b; req_words_i[3:2] = w; req_carry_i[1] = c;
    end
  endtask

  task automatic do_reset;
    rst_i = 1'b1; req_valid_i = '0; rsp_ready_i = 1'b0;
    tick; tick;
    rst_i = 1'b0;
  endtask

  // Leaves the bench at the negedge of the first DONE cycle when ok=1.
  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      mid;
      if (rsp_valid_o) begin ok = 1'b1; break; end
      tick;
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1; req_valid_i = '0; rsp_ready_i = 1'b0;
    req_op1_i = '0; req_op2_i = '0; req_words_i = '0; req_carry_i = '0;
    tick; tick;
    mid;
    n_cmp++; if (req_ready_o !== 2'b00) begin n_bad++; $display("FAIL rst_ready: got %b exp 00", req_ready_o); end
    n_cmp++; if (add_op1_o !== 32'h0) begin n_bad++; $display("FAIL rst_op1: got %h exp 0", add_op1_o); end
    n_cmp++; if (add_op2_o !== 32'h0) begin n_bad++; $display("FAIL rst_op2: got %h exp 0", add_op2_o); end
    n_cmp++; if (add_carry_o !== 1'b0) begin n_bad++; $display("FAIL rst_acarry: got %b exp 0", add_carry_o); end
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b exp 0", rsp_valid_o); end
    n_cmp++; if (rsp_id_o !== 1'b0) begin n_bad++; $display("FAIL rst_id: got %b exp 0", rsp_id_o); end
    n_cmp++; if (rsp_sum_o !== 128'h0) begin n_bad++; $display("FAIL rst_sum: got %h exp 0", rsp_sum_o); end
    n_cmp++; if (rsp_carry_o !== 1'b0) begin n_bad++; $display("FAIL rst_carry: got %b exp 0", rsp_carry_o); end
`ifdef ADDER_SEQ_OVERFLOW_EN
    n_cmp++; if (rsp_ovf_o !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b exp 0", rsp_ovf_o); end
`endif
    tick;
    rst_i = 1'b0;
  endtask

  task automatic test_single_word;
    bit ok;
    set_req(1'b0, 128'h0_0000_0000_0000_0000_0000_FFFF_FFFF, 128'h1, 2'd0, 1'b0);
    req_valid_i = 2'b01;
    mid;
    n_cmp++; if (req_ready_o !== 2'b01) begin n_bad++; $display("FAIL single_ready: got %b exp 01", req_ready_o); end
    tick; req_valid_i = 2'b00;
    mid;
    n_cmp++; if (add_op1_o !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL single_op1: got %h exp ffffffff", add_op1_o); end
    n_cmp++; if (add_op2_o !== 32'h1) begin n_bad++; $display("FAIL single_op2: got %h exp 1", add_op2_o); end
    n_cmp++; if (add_carry_o !== 1'b0) begin n_bad++; $display("FAIL single_cin: got %b exp 0", add_carry_o); end
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_bad++; $display("FAIL single_early: got %b exp 0", rsp_valid_o); end
    tick;
    mid;
    n_cmp++; if (rsp_valid_o !== 1'b1) begin n_bad++; $display("FAIL single_valid_T2: got %b exp 1", rsp_valid_o); end
    n_cmp++; if (rsp_sum_o !== 128'h0) begin n_bad++; $display("FAIL single_sum: got %h exp 0", rsp_sum_o); end
    n_cmp++; if (rsp_carry_o !== 1'b1) begin n_bad++; $display("FAIL single_cout: got %b exp 1", rsp_carry_o); end
    n_cmp++; if (rsp_id_o !== 1'b0) begin n_bad++; $display("FAIL single_id: got %b exp 0", rsp_id_o); end
    n_cmp++; if (add_op1_o !== 32'h0) begin n_bad++; $display("FAIL single_idle_op1: got %h exp 0", add_op1_o); end
    rsp_ready_i = 1'b1; tick; rsp_ready_i = 1'b0;
    // 5 + 7 + carry-in 1
    set_req(1'b0, 128'h5, 128'h7, 2'd0, 1'b1);
    req_valid_i = 2'b01;
    tick; req_valid_i = 2'b00;
    wait_done(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single2_timeout: got no response exp response"); end
    n_cmp++; if (rsp_sum_o !== 128'hD) begin n_bad++; $display("FAIL single2_sum: got %h exp d", rsp_sum_o); end
    n_cmp++; if (rsp_carry_o !== 1'b0) begin n_bad++; $display("FAIL single2_cout: got %b exp 0", rsp_carry_o); end
    rsp_ready_i = 1'b1; tick; rsp_ready_i = 1'b0;
  endtask

  task automatic test_ripple;
    bit ok;
    logic [3:0] exp_cin;
    exp_cin = 4'b1110;
    set_req(1'b0, {128{1'b1}}, 128'h1, 2'd3, 1'b0);
    req_valid_i = 2'b01;
    mid;
    n_cmp++; if (req_ready_o !== 2'b01) begin n_bad++; $display("FAIL ripple_ready: got %b exp 01", req_ready_o); end
    tick; req_valid_i = 2'b00;
    for (int k = 0; k < 4; k++) begin
      mid;
      n_cmp++; if (add_carry_o !== exp_cin[k]) begin n_bad++; $display("FAIL ripple_cin%0d: got %b exp %b", k, add_carry_o, exp_cin[k]); end
      n_cmp++; if (add_op2_o !== ((k == 0) ? 32'h1 : 32'h0)) begin n_bad++; $display("FAIL ripple_op2_%0d: got %h", k, add_op2_o); end
      n_cmp++; if (rsp_valid_o !== 1'b0) begin n_bad++; $display("FAIL ripple_early%0d: got %b exp 0", k, rsp_valid_o); end
      tick;
    end
    mid;
    n_cmp++; if (rsp_valid_o !== 1'b1) begin n_bad++; $display("FAIL ripple_valid_T5: got %b exp 1", rsp_valid_o); end
    n_cmp++; if (rsp_sum_o !== 128'h0) begin n_bad++; $display("FAIL ripple_sum: got %h exp 0", rsp_sum_o); end
    n_cmp++; if (rsp_carry_o !== 1'b1) begin n_bad++; $display("FAIL ripple_cout: got %b exp 1", rsp_carry_o); end
    rsp_ready_i = 1'b1; tick; rsp_ready_i = 1'b0;
    // Two-word add; garbage in the upper operand words must not leak into the sum
    set_req(1'b0, 128'h0000DEAD_0000BEEF_00000001_80000000,
                  128'h00001234_00005678_00000002_80000000, 2'd1, 1'b1);
    req_valid_i = 2'b01;
    tick; req_valid_i = 2'b00;
    wait_done(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL ripple2_timeout: got no response exp response"); end
    n_cmp++; if (rsp_sum_o !== 128'h00000000_00000000_00000004_00000001) begin n_bad++; $display("FAIL ripple2_sum: got %h exp 4_00000001", rsp_sum_o); end
    n_cmp++; if (rsp_carry_o !== 1'b0) begin n_bad++; $display("FAIL ripple2_cout: got %b exp 0", rsp_carry_o); end
    rsp_ready_i = 1'b1; tick; rsp_ready_i = 1'b0;
  endtask

  task automatic test_arbitration;
    int          acc_cyc [5];
    logic [1:0]  acc_rdy [5];
    logic [0:0]  ids     [4];
    logic [127:0] sums   [4];
    int          na, nr;
    logic [1:0]  exp_rdy [4];
    logic [0:0]  exp_id  [4];
    logic [127:0] exp_sum [4];
    exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_id  = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_sum = '{128'd2, 128'd30, 128'd2, 128'd30};
    na = 0; nr = 0;
    do_reset;
    set_req(1'b0, 128'd1, 128'd1, 2'd0, 1'b0);
    set_req(1'b1, 128'd10, 128'd20, 2'd0, 1'b0);
    req_valid_i = 2'b11; rsp_ready_i = 1'b1;
    for (int c = 0; c < 40 && nr < 4; c++) begin
      mid;
      if (req_ready_o != 2'b00 && na < 5) begin acc_cyc[na] = c; acc_rdy[na] = req_ready_o; na++; end
      if (rsp_valid_o) begin ids[nr] = rsp_id_o; sums[nr] = rsp_sum_o; nr++; end
      tick;
    end
    req_valid_i = 2'b00; rsp_ready_i = 1'b0;
    n_cmp++; if (nr != 4 || na < 4) begin n_bad++; $display("FAIL arb_timeout: got %0d rsp %0d acc exp 4 4", nr, na); end
    for (int i = 0; i < 4; i++) begin
      if (i < nr) begin
        n_cmp++; if (ids[i] !== exp_id[i]) begin n_bad++; $display("FAIL arb_id%0d: got %b exp %b", i, ids[i], exp_id[i]); end
        n_cmp++; if (sums[i] !== exp_sum[i]) begin n_bad++; $display("FAIL arb_sum%0d: got %h exp %h", i, sums[i], exp_sum[i]); end
      end
      if (i < na) begin
        n_cmp++; if (acc_rdy[i] !== exp_rdy[i]) begin n_bad++; $display("FAIL arb_ready%0d: got %b exp %b", i, acc_rdy[i], exp_rdy[i]); end
      end
      if (i > 0 && i < na) begin
        n_cmp++; if (acc_cyc[i] - acc_cyc[i-1] != 3) begin n_bad++; $display("FAIL arb_interval%0d: got %0d exp 3", i, acc_cyc[i] - acc_cyc[i-1]); end
      end
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    set_req(1'b0, 128'd3, 128'd4, 2'd0, 1'b0);
    set_req(1'b1, 128'd100, 128'd200, 2'd0, 1'b0);
    req_valid_i = 2'b11; rsp_ready_i = 1'b0;
    mid;
    n_cmp++; if (req_ready_o !== 2'b01) begin n_bad++; $display("FAIL bp_ready0: got %b exp 01", req_ready_o); end
    tick; req_valid_i = 2'b10;
    mid;
    n_cmp++; if (req_ready_o !== 2'b00) begin n_bad++; $display("FAIL bp_run_ready: got %b exp 00", req_ready_o); end
    tick;
    for (int i = 0; i < 3; i++) begin
      mid;
      n_cmp++; if (rsp_valid_o !== 1'b1) begin n_bad++; $display("FAIL bp_valid%0d: got %b exp 1", i, rsp_valid_o); end
      n_cmp++; if (rsp_sum_o !== 128'd7) begin n_bad++; $display("FAIL bp_sum%0d: got %h exp 7", i, rsp_sum_o); end
      n_cmp++; if (rsp_id_o !== 1'b0) begin n_bad++; $display("FAIL bp_id%0d: got %b exp 0", i, rsp_id_o); end
      n_cmp++; if (req_ready_o !== 2'b00) begin n_bad++; $display("FAIL bp_ready_hold%0d: got %b exp 00", i, req_ready_o); end
      tick;
    end
    mid;
    n_cmp++; if (rsp_valid_o !== 1'b1) begin n_bad++; $display("FAIL bp_valid3: got %b exp 1", rsp_valid_o); end
    rsp_ready_i = 1'b1;
    tick; rsp_ready_i = 1'b0;
    mid;
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_bad++; $display("FAIL bp_released: got %b exp 0", rsp_valid_o); end
    n_cmp++; if (req_ready_o !== 2'b10) begin n_bad++; $display("FAIL bp_next_accept: got %b exp 10", req_ready_o); end
    tick; req_valid_i = 2'b00;
    wait_done(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp2_timeout: got no response exp response"); end
    n_cmp++; if (rsp_id_o !== 1'b1) begin n_bad++; $display("FAIL bp2_id: got %b exp 1", rsp_id_o); end
    n_cmp++; if (rsp_sum_o !== 128'd300) begin n_bad++; $display("FAIL bp2_sum: got %h exp 12c", rsp_sum_o); end
    rsp_ready_i = 1'b1; tick; rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset_in_run;
    bit ok;
    do_reset;
    set_req(1'b0, 128'h00000004_00000003_00000002_00000001,
                  128'h00000028_0000001E_00000014_0000000A, 2'd3, 1'b0);
    req_valid_i = 2'b01;
    tick; req_valid_i = 2'b00;
    mid;
    n_cmp++; if (add_op1_o !== 32'd1) begin n_bad++; $display("FAIL rr_word0: got %h exp 1", add_op1_o); end
    tick; rst_i = 1'b1;
    mid;
    n_cmp++; if (add_op2_o !== 32'd20) begin n_bad++; $display("FAIL rr_word1: got %h exp 14", add_op2_o); end
    tick; rst_i = 1'b0;
    mid;
    n_cmp++; if (add_op1_o !== 32'h0 || add_op2_o !== 32'h0 || add_carry_o !== 1'b0) begin n_bad++; $display("FAIL rr_add_zero: got %h %h %b exp 0 0 0", add_op1_o, add_op2_o, add_carry_o); end
    n_cmp++; if (rsp_valid_o !== 1'b0 || rsp_sum_o !== 128'h0 || rsp_id_o !== 1'b0 || rsp_carry_o !== 1'b0) begin n_bad++; $display("FAIL rr_rsp_zero: got v=%b sum=%h exp 0", rsp_valid_o, rsp_sum_o); end
    n_cmp++; if (req_ready_o !== 2'b00) begin n_bad++; $display("FAIL rr_ready_zero: got %b exp 00", req_ready_o); end
    tick; req_valid_i = 2'b01;
    mid;
    n_cmp++; if (req_ready_o !== 2'b01) begin n_bad++; $display("FAIL rr_reaccept: got %b exp 01", req_ready_o); end
    tick; req_valid_i = 2'b00;
    mid;
    n_cmp++; if (add_op1_o !== 32'd1 || add_op2_o !== 32'd10) begin n_bad++; $display("FAIL rr_restart_word0: got %h %h exp 1 a", add_op1_o, add_op2_o); end
    tick;
    wait_done(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rr_timeout: got no response exp response"); end
    n_cmp++; if (rsp_sum_o !== 128'h0000002C_00000021_00000016_0000000B) begin n_bad++; $display("FAIL rr_sum: got %h exp 2c_21_16_0b", rsp_sum_o); end
    rsp_ready_i = 1'b1; tick; rsp_ready_i = 1'b0;
  endtask

`ifdef ADDER_SEQ_OVERFLOW_EN
  task automatic test_overflow;
    bit ok;
    set_req(1'b0, 128'h7FFF_FFFF, 128'h1, 2'd0, 1'b0);
    req_valid_i = 2'b01;
    tick; req_valid_i = 2'b00;
    wait_done(ok);
    n_cmp++; if (!ok || rsp_ovf_o !== 1'b1) begin n_bad++; $display("FAIL ovf_pos: got %b exp 1", rsp_ovf_o); end
    rsp_ready_i = 1'b1; tick; rsp_ready_i = 1'b0;
    set_req(1'b0, 128'hFFFF_FFFF, 128'h1, 2'd0, 1'b0);
    req_valid_i = 2'b01;
    tick; req_valid_i = 2'b00;
    wait_done(ok);
    n_cmp++; if (!ok || rsp_ovf_o !== 1'b0) begin n_bad++; $display("FAIL ovf_wrap: got %b exp 0", rsp_ovf_o); end
    rsp_ready_i = 1'b1; tick; rsp_ready_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_single_word;
    test_ripple;
    test_arbitration;
    test_backpressure;
    test_reset_in_run;
`ifdef ADDER_SEQ_OVERFLOW_EN
    test_overflow;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish exp finish before 100000");
    $fatal(1);
  end

endmodule
